// File: rtl/adc_capture_ctrl.sv
// Triggered capture sequencer: decimates the ADC stream into a circular sample RAM,
// keeps a pre-trigger window, detects a level crossing and completes the post-trigger fill.
// Latency: one adc_clk from strobed sample to registered RAM write; no backpressure (the RAM always accepts).
//
// Ports:
//   adc_clk, rstn              sample clock, synchronous active-low reset
//   adc_data                   ADC sample, valid every cycle
//   cfg_arm / cfg_abort        one-cycle control pulses (abort wins when both are high)
//   cfg_mode/level/pretrig/decim  capture configuration, latched on an accepted arm
//   mem_we/mem_waddr/mem_wdata registered write port to the external sample RAM
//   busy, done, trig_out       status: capture running, completion pulse, trigger-write pulse
//   trig_addr, start_addr      trigger sample address and oldest valid sample address
//   state                      0 IDLE, 1 PRE, 2 WAIT_TRIG, 3 POST, 4 DONE
module adc_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              adc_clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic [ADDR_W-1:0] cfg_pretrig,
    input  logic [7:0]        cfg_decim,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              trig_out,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic [2:0]        state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] M_IMM    = 2'd0;
    localparam logic [1:0] M_RISE   = 2'd1;
    localparam logic [1:0] M_FALL   = 2'd2;
    localparam logic [1:0] M_EITHER = 2'd3;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};  // DEPTH-1

    // Registered state
    logic [2:0]        state_q,        state_d;
    logic [ADDR_W-1:0] wptr_q,         wptr_d;
    logic [7:0]        div_cnt_q,      div_cnt_d;
    logic [ADDR_W-1:0] pre_cnt_q,      pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q,     post_cnt_d;
    logic [DATA_W-1:0] prev_q,         prev_d;
    logic              prev_valid_q,   prev_valid_d;

    // Latched configuration
    logic [1:0]        mode_q,         mode_d;
    logic [DATA_W-1:0] level_q,        level_d;
    logic [ADDR_W-1:0] pretrig_q,      pretrig_d;
    logic [7:0]        decim_q,        decim_d;

    // Registered outputs
    logic              mem_we_q,       mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q,    mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
    logic              done_q,         done_d;
    logic              trig_out_q,     trig_out_d;
    logic [ADDR_W-1:0] trig_addr_q,    trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q,   start_addr_d;

    // Combinational helpers
    logic              busy_w;
    logic              strobe;
    logic              rise_hit;
    logic              fall_hit;
    logic              trig_hit;
    logic [ADDR_W-1:0] post_len;

    always_comb begin
        busy_w   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        strobe   = busy_w && (div_cnt_q == 8'd0);

        // Unsigned level crossing between the previous kept sample and the current one.
        rise_hit = prev_valid_q && (prev_q <  level_q) && (adc_data >= level_q);
        fall_hit = prev_valid_q && (prev_q >= level_q) && (adc_data <  level_q);

        case (mode_q)
            M_IMM:    trig_hit = 1'b1;
            M_RISE:   trig_hit = rise_hit;
            M_FALL:   trig_hit = fall_hit;
            M_EITHER: trig_hit = rise_hit || fall_hit;
            default:  trig_hit = 1'b0;
        endcase

        // Samples still to be written after the trigger so the capture totals DEPTH.
        post_len = A_MAX - pretrig_q;
    end

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        div_cnt_d    = div_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        mode_d       = mode_q;
        level_d      = level_q;
        pretrig_d    = pretrig_q;
        decim_d      = decim_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        trig_out_d   = 1'b0;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;

        if (cfg_abort) begin
            // Abort beats everything, including a simultaneous arm; addresses are kept.
            state_d = S_IDLE;
        end else if (cfg_arm && !busy_w) begin
            mode_d       = cfg_mode;
            level_d      = cfg_level;
            // The port is ADDR_W bits wide, so it can never exceed DEPTH-1: the clamp is implicit.
            pretrig_d    = cfg_pretrig;
            decim_d      = cfg_decim;
            wptr_d       = '0;
            div_cnt_d    = 8'd0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            prev_valid_d = 1'b0;
            state_d      = (cfg_pretrig == '0) ? S_WAIT : S_PRE;
        end else if (busy_w) begin
            div_cnt_d = (div_cnt_q == 8'd0) ? decim_q : (div_cnt_q - 8'd1);

            if (strobe) begin
                mem_we_d     = 1'b1;
                mem_waddr_d  = wptr_q;
                mem_wdata_d  = adc_data;
                wptr_d       = wptr_q + A_ONE;
                prev_d       = adc_data;
                prev_valid_d = 1'b1;

                case (state_q)
                    S_PRE: begin
                        pre_cnt_d = pre_cnt_q + A_ONE;
                        if ((pre_cnt_q + A_ONE) == pretrig_q) begin
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (trig_hit) begin
                            trig_out_d  = 1'b1;
                            trig_addr_d = wptr_q;
                            post_cnt_d  = post_len;
                            if (post_len == '0) begin
                                // Pre-trigger window fills the whole RAM: finish on the trigger write.
                                state_d      = S_DONE;
                                done_d       = 1'b1;
                                start_addr_d = wptr_q - pretrig_q;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        post_cnt_d = post_cnt_q - A_ONE;
                        if (post_cnt_q == A_ONE) begin
                            // Last write registers on the same edge the state enters DONE.
                            state_d      = S_DONE;
                            done_d       = 1'b1;
                            start_addr_d = trig_addr_q - pretrig_q;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            div_cnt_q    <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            mode_q       <= '0;
            level_q      <= '0;
            pretrig_q    <= '0;
            decim_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            trig_out_q   <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            div_cnt_q    <= div_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            pretrig_q    <= pretrig_d;
            decim_q      <= decim_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            trig_out_q   <= trig_out_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_w;
    assign done       = done_q;
    assign trig_out   = trig_out_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    assign state      = state_q;

endmodule
